// File: rtl/rmon_pkg.sv
// Shared types and helpers for the ripple counter monitor.
package rmon_pkg;

  localparam int unsigned CNT_W_DEF       = 4;
  localparam int unsigned EXT_W_DEF       = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_REPORT = 2'd2
  } rmon_state_e;

  // Extended value {wrap, count}; callers truncate to EXT_W+CNT_W (<= 32).
  function automatic logic [31:0] rmon_ext_value(input logic [31:0] wrap,
                                                 input logic [31:0] val,
                                                 input int unsigned cnt_w);
    return (wrap << cnt_w) | val;
  endfunction

endpackage

// File: rtl/rmon_sync_filter.sv
// Synchroniser chain for the ripple counter outputs plus a two-sample stability filter.
module rmon_sync_filter
  import rmon_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [CNT_W-1:0] filt_o,
  output logic [CNT_W-1:0] sample_o,
  output logic             upd_o
);

  logic [CNT_W-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] filt_q;
  logic [CNT_W-1:0] filt_d;
  logic             stable_s;

  // Comparing the last two stages rejects any value seen on only one sample.
  assign stable_s = (sync_q[SYNC_STAGES-1] == sync_q[SYNC_STAGES-2]);
  assign sample_o = sync_q[SYNC_STAGES-1];
  assign upd_o    = stable_s;
  assign filt_o   = filt_q;

  // Next filtered value: take the synchronised sample only when stable.
  always_comb begin
    filt_d = filt_q;
    if (stable_s) begin
      filt_d = sync_q[SYNC_STAGES-1];
    end else begin
      filt_d = filt_q;
    end
  end

  // Synchroniser chain and filtered value register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      filt_q <= '0;
    end else begin
      sync_q[0] <= cnt_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      filt_q <= filt_d;
    end
  end

endmodule

// File: rtl/ripple_count_monitor.sv
// Extends a filtered ripple count with a wrap counter and reports the first threshold crossing.
// Optional macro RMON_OVF_SAT_EN: saturate the wrap counter and raise a sticky ovf flag.
module ripple_count_monitor
  import rmon_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned EXT_W       = EXT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CNT_W-1:0]       cnt_in,
  input  logic                   arm,
  input  logic [EXT_W+CNT_W-1:0] threshold,
  output logic                   snap_valid,
  input  logic                   snap_ready,
  output logic [EXT_W+CNT_W-1:0] snap_data,
  output logic [EXT_W+CNT_W-1:0] ext_count,
  output logic                   busy,
  output logic                   ovf
);

  localparam int unsigned XW = EXT_W + CNT_W;

  logic [CNT_W-1:0] filt_s;
  logic [CNT_W-1:0] sample_s;
  logic             upd_s;
  logic             wrap_evt_s;
  logic             arm_accept_s;
  logic [XW-1:0]    ext_s;

  logic [EXT_W-1:0] wrap_q;
  logic [EXT_W-1:0] wrap_d;
  logic             ovf_q;
  logic             ovf_d;

  rmon_state_e      state_q;
  logic [XW-1:0]    thr_q;
  logic             snap_valid_q;
  logic [XW-1:0]    snap_data_q;
  logic             busy_q;

  rmon_sync_filter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt_i    (cnt_in),
    .filt_o   (filt_s),
    .sample_o (sample_s),
    .upd_o    (upd_s)
  );

  assign wrap_evt_s   = upd_s && (sample_s < filt_s);
  assign arm_accept_s = arm && (state_q == ST_IDLE);

  // Built purely from registers, so ext_count moves in the same cycle as the filtered value.
  assign ext_s = XW'(rmon_ext_value(32'(wrap_q), 32'(filt_s), CNT_W));

  // Wrap counter and overflow next-state; arming wins over a simultaneous wrap.
  always_comb begin
    wrap_d = wrap_q;
    ovf_d  = ovf_q;
    if (arm_accept_s) begin
      wrap_d = '0;
      ovf_d  = 1'b0;
    end else if (wrap_evt_s) begin
`ifdef RMON_OVF_SAT_EN
      if (wrap_q == '1) begin
        wrap_d = wrap_q;
        ovf_d  = 1'b1;
      end else begin
        wrap_d = wrap_q + EXT_W'(1'b1);
        ovf_d  = ovf_q;
      end
`else
      wrap_d = wrap_q + EXT_W'(1'b1);
      ovf_d  = 1'b0;
`endif
    end else begin
      wrap_d = wrap_q;
      ovf_d  = ovf_q;
    end
  end

  // Wrap counter and overflow flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  // Monitor FSM; compares the pre-update ext_count so a same-cycle update is seen next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      thr_q        <= '0;
      snap_valid_q <= 1'b0;
      snap_data_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            thr_q   <= threshold;
            busy_q  <= 1'b1;
            state_q <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (ext_s >= thr_q) begin
            snap_data_q  <= ext_s;
            snap_valid_q <= 1'b1;
            state_q      <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (snap_valid_q && snap_ready) begin
            snap_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          snap_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign snap_valid = snap_valid_q;
  assign snap_data  = snap_data_q;
  assign ext_count  = ext_s;
  assign busy       = busy_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Self-checking bench for ripple_count_monitor: step table, glitch, threshold, reset and wrap-overflow sequences.
module tb_ripple_count_monitor;

  localparam int CW = 4;
  localparam int EW = 4;
  localparam int XW = CW + EW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] cnt_in;
  logic          arm;
  logic [XW-1:0] threshold;
  logic          snap_valid;
  logic          snap_ready;
  logic [XW-1:0] snap_data;
  logic [XW-1:0] ext_count;
  logic          busy;
  logic          ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_reach;
  int t_valid;
  int bad;

  logic [XW-1:0] sb_q[$];

  typedef struct {
    logic [CW-1:0] cnt;
    logic [XW-1:0] exp_ext;
  } vec_t;
  vec_t vecs[16];

  ripple_count_monitor #(
    .CNT_W       (CW),
    .EXT_W       (EW),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_in     (cnt_in),
    .arm        (arm),
    .threshold  (threshold),
    .snap_valid (snap_valid),
    .snap_ready (snap_ready),
    .snap_data  (snap_data),
    .ext_count  (ext_count),
    .busy       (busy),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic hold(input logic [CW-1:0] v, input int n);
    cnt_in = v;
    repeat (n) tick();
  endtask

  task automatic hold_mon(input logic [CW-1:0] v, input int n, input logic [XW-1:0] thr);
    cnt_in = v;
    repeat (n) begin
      tick();
      if (ext_count >= thr && t_reach < 0) t_reach = cyc;
      if (snap_valid && t_valid < 0) t_valid = cyc;
    end
  endtask

  task automatic sb_check(input string name);
    logic [XW-1:0] exp;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got 0x%0h expected <none queued>", name, snap_data);
    end else begin
      exp = sb_q.pop_front();
      check(name, snap_data, exp);
    end
  endtask

  initial begin
    logic [XW-1:0] prev_exp;
    logic [EW-1:0] exp_wrap;
    logic          exp_ovf;

    rst_n      = 1'b0;
    arm        = 1'b0;
    snap_ready = 1'b0;
    cnt_in     = '0;
    threshold  = '0;

    for (int i = 0; i < 16; i++) begin
      vecs[i].cnt     = CW'((i + 1) % 16);
      vecs[i].exp_ext = XW'(i + 1);
    end

    // Reset state
    tick();
    tick();
    check("rst_ext_count", ext_count, 8'h00);
    check("rst_snap_valid", snap_valid, 1'b0);
    check("rst_snap_data", snap_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_ext", ext_count, 8'h00);
    check("post_rst_busy", busy, 1'b0);

    // Step table 1..15, 0: old value after 2 cycles, new value after 3
    prev_exp = 8'h00;
    for (int i = 0; i < 16; i++) begin
      cnt_in = vecs[i].cnt;
      tick();
      tick();
      check($sformatf("step%0d_early", i), ext_count, prev_exp);
      tick();
      check($sformatf("step%0d", i), ext_count, vecs[i].exp_ext);
      tick();
      prev_exp = vecs[i].exp_ext;
    end

    // Glitch 7 -> 6 -> 4 -> 8 with one-cycle transients
    hold(4'd7, 4);
    check("glitch_start", ext_count, 8'h17);
    bad = 0;
    cnt_in = 4'd6;
    tick();
    if (ext_count != 8'h17 && ext_count != 8'h18) bad++;
    cnt_in = 4'd4;
    tick();
    if (ext_count != 8'h17 && ext_count != 8'h18) bad++;
    cnt_in = 4'd8;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ext_count != 8'h17 && ext_count != 8'h18) bad++;
    end
    check("glitch_transient", bad, 0);
    check("glitch_final", ext_count, 8'h18);

    // Threshold 0x25 crossing, counting from 0
    hold(4'd0, 4);
    threshold = 8'h25;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_busy", busy, 1'b1);
    check("arm_clears_wrap", ext_count, 8'h00);
    sb_q.push_back(8'h25);
    t_reach = -1;
    t_valid = -1;
    for (int k = 1; k <= 37; k++) begin
      hold_mon(CW'(k % 16), 4, 8'h25);
    end
    hold_mon(4'd5, 2, 8'h25);
    check("thr_reached", (t_reach >= 0) ? 1 : 0, 1);
    check("valid_latency", (t_valid > t_reach && t_valid - t_reach <= 4) ? 1 : 0, 1);

    // Hold off the consumer; an arm during REPORT must be ignored
    bad = 0;
    cnt_in = 4'd6;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        arm = 1'b1;
        threshold = 8'h00;
      end
      tick();
      arm = 1'b0;
      if (!snap_valid || snap_data !== 8'h25 || !busy) bad++;
    end
    check("report_hold", bad, 0);
    snap_ready = 1'b1;
    sb_check("snap_data_thr25");
    tick();
    snap_ready = 1'b0;
    check("handshake_valid", snap_valid, 1'b0);
    check("handshake_busy", busy, 1'b0);
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
    check("ready_idle_ignored", snap_valid, 1'b0);

    // Threshold 0: snapshot one cycle after arm, then reset mid-REPORT
    threshold = 8'h00;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("thr0_first_cycle_valid", snap_valid, 1'b0);
    check("thr0_busy", busy, 1'b1);
    sb_q.push_back(8'h06);
    tick();
    check("thr0_valid", snap_valid, 1'b1);
    sb_check("snap_data_thr0");
    #3;
    rst_n = 1'b0;
    #1;
    check("midrpt_rst_valid", snap_valid, 1'b0);
    check("midrpt_rst_busy", busy, 1'b0);
    check("midrpt_rst_ext", ext_count, 8'h00);
    sb_q.delete();
    cnt_in = 4'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("sb_empty", sb_q.size(), 0);

    // 17 wraps of the ripple counter
    for (int w = 0; w < 17; w++) begin
      hold(4'd8, 4);
      hold(4'd0, 4);
    end
`ifdef RMON_OVF_SAT_EN
    exp_wrap = 4'hF;
    exp_ovf  = 1'b1;
`else
    exp_wrap = 4'h1;
    exp_ovf  = 1'b0;
`endif
    check("wrap17_ext", ext_count, {exp_wrap, 4'h0});
    check("wrap17_ovf", ovf, exp_ovf);
    tick();
    check("wrap17_ovf_sticky", ovf, exp_ovf);
    threshold = 8'hFF;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_clears_ovf", ovf, 1'b0);
    check("arm_clears_wrap2", ext_count, 8'h00);
    check("armed_busy", busy, 1'b1);
    tick();
    check("armed_no_snap", snap_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
